// File: rtl/adc128s022_cmd_ctrl.sv
// Command-driven controller for the ADC128S022: a start edge on the NIOS command word runs an
// address frame and a data frame, then publishes the 12-bit result with its channel and valid flag.
module adc128s022_cmd_ctrl #(
    parameter int CLK_DIV = 10
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [3:0]  i_adc_cmd,
    output logic [11:0] o_adc_data,
    output logic [3:0]  o_adc_channel_data_valid,
    output logic        o_busy,
    output logic        o_adc_cs_n,
    output logic        o_adc_sclk,
    output logic        o_adc_din,
    input  logic        i_adc_dout
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FRAME1 = 3'd1,
        GAP    = 3'd2,
        FRAME2 = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic             start_prev_reg;
    logic [2:0]       ch_reg, ch_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [15:0]      shift_reg, shift_next;
    logic             dout_meta_reg, dout_sync_reg;
    logic             cs_n_reg, cs_n_next;
    logic             sclk_reg, sclk_next;
    logic             din_reg, din_next;
    logic [11:0]      data_reg, data_next;
    logic [3:0]       valid_reg, valid_next;
    logic             busy_reg, busy_next;

    logic        start_edge;
    logic        div_last;
    logic        in_frame;
    logic        frame_end;
    logic [15:0] din_word;

    assign start_edge = (state_reg == IDLE) && i_adc_cmd[3] && !start_prev_reg;
    assign div_last   = (div_cnt_reg == DIV_LAST);
    assign in_frame   = (state_reg == FRAME1) || (state_reg == FRAME2);
    assign frame_end  = in_frame && sclk_reg && div_last && (bit_cnt_reg == 4'd0);
    // Built from ch_next so the first DIN bit is right on the start-edge cycle itself.
    assign din_word   = {2'b00, ch_next, 11'b0};

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_edge) state_next = FRAME1;
            FRAME1:  if (frame_end)  state_next = GAP;
            GAP:     if (div_last)   state_next = FRAME2;
            FRAME2:  if (frame_end)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ch_next      = ch_reg;
        div_cnt_next = div_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        cs_n_next    = cs_n_reg;
        sclk_next    = sclk_reg;
        din_next     = din_reg;
        data_next    = data_reg;
        valid_next   = valid_reg;
        busy_next    = busy_reg;
        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    ch_next       = i_adc_cmd[2:0];
                    valid_next[3] = 1'b0;
                    busy_next     = 1'b1;
                    cs_n_next     = 1'b0;
                    sclk_next     = 1'b0;
                    div_cnt_next  = '0;
                    bit_cnt_next  = 4'd15;
                    din_next      = din_word[15];
                end
            end
            FRAME1, FRAME2: begin
                div_cnt_next = div_last ? '0 : div_cnt_reg + DIV_W'(1);
                if (div_last) begin
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                    end else begin
                        // End of the high phase: capture DOUT, then either open the next bit or close the frame.
                        shift_next = {shift_reg[14:0], dout_sync_reg};
                        if (bit_cnt_reg == 4'd0) begin
                            cs_n_next = 1'b1;
                            din_next  = 1'b0;
                        end else begin
                            bit_cnt_next = bit_cnt_reg - 4'd1;
                            sclk_next    = 1'b0;
                            din_next     = din_word[bit_cnt_reg - 4'd1];
                        end
                    end
                end
            end
            GAP: begin
                div_cnt_next = div_cnt_reg + DIV_W'(1);
                if (div_last) begin
                    cs_n_next    = 1'b0;
                    sclk_next    = 1'b0;
                    div_cnt_next = '0;
                    bit_cnt_next = 4'd15;
                    din_next     = din_word[15];
                end
            end
            DONE: begin
                data_next  = shift_reg[11:0];
                valid_next = {1'b1, ch_reg};
                busy_next  = 1'b0;
                cs_n_next  = 1'b1;
            end
            default: begin
                cs_n_next = 1'b1;
                sclk_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            start_prev_reg <= 1'b0;
            ch_reg         <= '0;
            div_cnt_reg    <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            dout_meta_reg  <= 1'b0;
            dout_sync_reg  <= 1'b0;
            cs_n_reg       <= 1'b1;
            sclk_reg       <= 1'b1;
            din_reg        <= 1'b0;
            data_reg       <= '0;
            valid_reg      <= '0;
            busy_reg       <= 1'b0;
        end else begin
            start_prev_reg <= i_adc_cmd[3];
            ch_reg         <= ch_next;
            div_cnt_reg    <= div_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            dout_meta_reg  <= i_adc_dout;
            dout_sync_reg  <= dout_meta_reg;
            cs_n_reg       <= cs_n_next;
            sclk_reg       <= sclk_next;
            din_reg        <= din_next;
            data_reg       <= data_next;
            valid_reg      <= valid_next;
            busy_reg       <= busy_next;
        end
    end

    assign o_adc_cs_n               = cs_n_reg;
    assign o_adc_sclk               = sclk_reg;
    assign o_adc_din                = din_reg;
    assign o_adc_data               = data_reg;
    assign o_adc_channel_data_valid = valid_reg;
    assign o_busy                   = busy_reg;

endmodule
